in_demux: RTL and testbench
===========================

# in_demux

Write-side companion of the GPIO output multiplexer: decodes PS-issued address/data words arriving on the GPIO input bank and commits them into the lock-in/OPO-locking configuration registers (NCO frequency, phase offset, LPF shift, control bits). A toggle-strobe/toggle-ack handshake makes each write an explicit transaction. 48-bit NCO frequency writes are assembled from two GPIO writes and committed atomically. The block sits between the PS GPIO and the demodulator/PID datapath, in the fabric clock domain.

## Interface
- No parameters; register addresses are fixed and live in IOAddress: freq_lo_IN=16'h0010, freq_hi_IN=16'h0011, phase_IN=16'h0012, lpf_IN=16'h0013, ctrl_IN=16'h0014.
- clk  in  1  fabric clock
- rst  in  1  reset, synchronous, active-low
- gpio_addr  in  16  register address; held stable by PS from before strobe toggle until ack toggle
- gpio_data  in  32  write data; same stability rule
- gpio_strobe  in  1  PS toggles once per write request
- gpio_ack  out  1  toggles once per completed transaction
- freq_word  out  48  NCO phase increment
- freq_update  out  1  one-cycle pulse when freq_word changes
- phase_off  out  20  demodulator phase offset
- lpf_shift  out  5  low-pass filter shift
- lock_en  out  1  lock loop enable
- demod_rst_n  out  1  active-low soft reset to demodulator
- addr_err  out  1  sticky: write to unmapped address seen

## Operation
- Strobe path: strobe_s (synchronized or raw strobe, see Configuration) compared with register strobe_seen; mismatch = pending request.
- FSM IDLE -> DECODE -> COMMIT -> ACK -> IDLE, one cycle per non-IDLE state.
- IDLE: on pending request latch addr_q<=gpio_addr, data_q<=gpio_data, strobe_seen<=strobe_s, go DECODE; else stay.
- DECODE: compare addr_q to the five addresses, register one-hot hit and miss flag.
- COMMIT: freq_lo_IN: shadow<=data_q. freq_hi_IN: freq_word<={data_q[15:0],shadow}, freq_update<=1. phase_IN: phase_off<=data_q[19:0]. lpf_IN: lpf_shift<=data_q[4:0]. ctrl_IN: lock_en<=data_q[0], demod_rst_n<=data_q[1], addr_err<=0 if data_q[31]. Miss: no register write, addr_err<=1.
- ACK: gpio_ack<=~gpio_ack; freq_update returns 0; go IDLE.
- Unused data bits ignored. freq_word never changes on a freq_lo_IN write; freq_hi_IN without prior freq_lo_IN commits current shadow (0 after reset).
- Toggle arriving while not IDLE stays pending (strobe_seen only updates in IDLE) and is served on return to IDLE. Two toggles during one busy window cancel: protocol violation, PS waits for ack before next toggle.
- Reset values: gpio_ack 0, freq_word 0, shadow 0, freq_update 0, phase_off 0, lpf_shift 5'd10, lock_en 0, demod_rst_n 0, addr_err 0, strobe_seen 0, sync flops 0, state IDLE.
- Reset mid-transaction aborts it: no commit, no ack toggle. PS driver returns its strobe to 0 alongside rst; a strobe of 1 after reset release is served as a request.

## Timing
- With sync: toggle sampled at edge k; pending visible after k+1; IDLE->DECODE at k+2; COMMIT k+3; register/freq_update valid after k+4; gpio_ack toggles at k+5.
- Without sync: all above 2 cycles earlier (register update at k+2, ack at k+3).
- Throughput: one write per 4 cycles once pending; freq_update high exactly 1 cycle, coincident with new freq_word.
- Outputs registered; no combinational path from gpio_* to outputs.

## Configuration
- GPIO_SYNC_EN defined: gpio_strobe passes a 2-flop synchronizer before compare; address/data still captured directly (protected by stability rule).
- Undefined: gpio_strobe registered once, used directly (PS GPIO in clk domain); latency reduced by 2.

## Test plan
- Reset: hold rst=0 5 cycles -> lpf_shift=10, all other outputs 0, gpio_ack=0.
- Write freq_lo_IN 32'hDEADBEEF then freq_hi_IN 32'h00001234 -> freq_word stays 0 after first, becomes 48'h1234DEADBEEF after second with one freq_update pulse; two ack toggles.
- Write phase_IN 32'hFFFABCDE -> phase_off=20'hABCDE, ack toggles at k+5 (GPIO_SYNC_EN) / k+3 (without).
- Write 16'h0099 -> no register changes, addr_err=1; then ctrl_IN 32'h80000003 -> addr_err=0, lock_en=1, demod_rst_n=1.
- Toggle strobe during DECODE of previous write -> second write served after first ack, two acks total, both registers updated.
- Assert rst during COMMIT of lpf_IN 7 -> lpf_shift=10, gpio_ack unchanged at 0.

Source files
------------

// File: rtl/in_demux.sv
// GPIO write-side decoder: commits PS address/data writes into lock-in configuration registers.
// Optional GPIO_SYNC_EN: pass gpio_strobe through a 2-flop synchronizer (adds 2 cycles of latency).
module in_demux (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] gpio_addr,
    input  logic [31:0] gpio_data,
    input  logic        gpio_strobe,
    output logic        gpio_ack,
    output logic [47:0] freq_word,
    output logic        freq_update,
    output logic [19:0] phase_off,
    output logic [4:0]  lpf_shift,
    output logic        lock_en,
    output logic        demod_rst_n,
    output logic        addr_err
);

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned PHASE_W = 20;
    localparam int unsigned LPF_W   = 5;
    localparam int unsigned N_REG   = 5;

    // IOAddress register map
    localparam logic [ADDR_W-1:0] freq_lo_IN = 16'h0010;
    localparam logic [ADDR_W-1:0] freq_hi_IN = 16'h0011;
    localparam logic [ADDR_W-1:0] phase_IN   = 16'h0012;
    localparam logic [ADDR_W-1:0] lpf_IN     = 16'h0013;
    localparam logic [ADDR_W-1:0] ctrl_IN    = 16'h0014;

    localparam int unsigned HIT_FLO   = 0;
    localparam int unsigned HIT_FHI   = 1;
    localparam int unsigned HIT_PHASE = 2;
    localparam int unsigned HIT_LPF   = 3;
    localparam int unsigned HIT_CTRL  = 4;

    localparam logic [LPF_W-1:0] LPF_RESET = 5'd10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        COMMIT = 2'd2,
        ACK    = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                strobe_s;
    logic                strobe_seen;
    logic                pending_c;
    logic                capture_c;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [N_REG-1:0]    hit_q;
    logic                miss_q;
    logic [DATA_W-1:0]   shadow;

`ifdef GPIO_SYNC_EN
    logic strobe_meta;
    logic strobe_sync;

    always_ff @(posedge clk) begin
        if (!rst) begin
            strobe_meta <= 1'b0;
            strobe_sync <= 1'b0;
        end else begin
            strobe_meta <= gpio_strobe;
            strobe_sync <= strobe_meta;
        end
    end

    assign strobe_s = strobe_sync;
`else
    // PS GPIO already in clk domain; strobe_seen is the only register on this path
    assign strobe_s = gpio_strobe;
`endif

    assign pending_c = (strobe_s != strobe_seen);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        capture_c = 1'b0;
        case (state)
            IDLE: begin
                if (pending_c) begin
                    capture_c = 1'b1;
                    state_nxt = DECODE;
                end
            end
            DECODE:  state_nxt = COMMIT;
            COMMIT:  state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture and address decode
    always_ff @(posedge clk) begin
        if (!rst) begin
            strobe_seen <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            hit_q       <= '0;
            miss_q      <= 1'b0;
        end else begin
            if (capture_c) begin
                strobe_seen <= strobe_s;
                addr_q      <= gpio_addr;
                data_q      <= gpio_data;
            end
            if (state == DECODE) begin
                hit_q[HIT_FLO]   <= (addr_q == freq_lo_IN);
                hit_q[HIT_FHI]   <= (addr_q == freq_hi_IN);
                hit_q[HIT_PHASE] <= (addr_q == phase_IN);
                hit_q[HIT_LPF]   <= (addr_q == lpf_IN);
                hit_q[HIT_CTRL]  <= (addr_q == ctrl_IN);
                miss_q           <= !(addr_q inside {freq_lo_IN, freq_hi_IN, phase_IN, lpf_IN, ctrl_IN});
            end
        end
    end

    // Register commit and ack toggle
    always_ff @(posedge clk) begin
        if (!rst) begin
            gpio_ack    <= 1'b0;
            freq_word   <= '0;
            shadow      <= '0;
            freq_update <= 1'b0;
            phase_off   <= '0;
            lpf_shift   <= LPF_RESET;
            lock_en     <= 1'b0;
            demod_rst_n <= 1'b0;
            addr_err    <= 1'b0;
        end else begin
            if (state == COMMIT) begin
                if (hit_q[HIT_FLO]) begin
                    shadow <= data_q;
                end
                // Upper 16 bits join the shadowed low word so the 48-bit update is atomic
                if (hit_q[HIT_FHI]) begin
                    freq_word   <= {data_q[15:0], shadow};
                    freq_update <= 1'b1;
                end
                if (hit_q[HIT_PHASE]) begin
                    phase_off <= data_q[PHASE_W-1:0];
                end
                if (hit_q[HIT_LPF]) begin
                    lpf_shift <= data_q[LPF_W-1:0];
                end
                if (hit_q[HIT_CTRL]) begin
                    lock_en     <= data_q[0];
                    demod_rst_n <= data_q[1];
                    if (data_q[31]) begin
                        addr_err <= 1'b0;
                    end
                end
                if (miss_q) begin
                    addr_err <= 1'b1;
                end
            end
            if (state == ACK) begin
                gpio_ack    <= ~gpio_ack;
                freq_update <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_in_demux.sv
// Randomized self-checking bench for in_demux against a register-map reference model.
module tb_in_demux;

`ifdef GPIO_SYNC_EN
    localparam int ACK_LAT = 5;
`else
    localparam int ACK_LAT = 3;
`endif

    localparam logic [15:0] A_FLO   = 16'h0010;
    localparam logic [15:0] A_FHI   = 16'h0011;
    localparam logic [15:0] A_PHASE = 16'h0012;
    localparam logic [15:0] A_LPF   = 16'h0013;
    localparam logic [15:0] A_CTRL  = 16'h0014;

    logic        clk;
    logic        rst;
    logic [15:0] gpio_addr;
    logic [31:0] gpio_data;
    logic        gpio_strobe;
    logic        gpio_ack;
    logic [47:0] freq_word;
    logic        freq_update;
    logic [19:0] phase_off;
    logic [4:0]  lpf_shift;
    logic        lock_en;
    logic        demod_rst_n;
    logic        addr_err;

    int n_total;
    int n_bad;

    // Reference model state
    logic [31:0] m_shadow;
    logic [47:0] m_freq;
    logic [19:0] m_phase;
    logic [4:0]  m_lpf;
    logic        m_lock;
    logic        m_drst;
    logic        m_err;
    logic        m_ack;

    // Per-transaction observations
    int          lat;
    int          pulses;
    int          pulse_at;
    logic [47:0] pulse_word;

    in_demux dut (
        .clk         (clk),
        .rst         (rst),
        .gpio_addr   (gpio_addr),
        .gpio_data   (gpio_data),
        .gpio_strobe (gpio_strobe),
        .gpio_ack    (gpio_ack),
        .freq_word   (freq_word),
        .freq_update (freq_update),
        .phase_off   (phase_off),
        .lpf_shift   (lpf_shift),
        .lock_en     (lock_en),
        .demod_rst_n (demod_rst_n),
        .addr_err    (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_shadow = '0;
        m_freq   = '0;
        m_phase  = '0;
        m_lpf    = 5'd10;
        m_lock   = 1'b0;
        m_drst   = 1'b0;
        m_err    = 1'b0;
        m_ack    = 1'b0;
    endtask

    task automatic model_write(input logic [15:0] a, input logic [31:0] d);
        case (a)
            A_FLO:   m_shadow = d;
            A_FHI:   m_freq = {d[15:0], m_shadow};
            A_PHASE: m_phase = d[19:0];
            A_LPF:   m_lpf = d[4:0];
            A_CTRL: begin
                m_lock = d[0];
                m_drst = d[1];
                if (d[31]) m_err = 1'b0;
            end
            default: m_err = 1'b1;
        endcase
        m_ack = ~m_ack;
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".freq_word"}, 64'(freq_word), 64'(m_freq));
        check({tag, ".phase_off"}, 64'(phase_off), 64'(m_phase));
        check({tag, ".lpf_shift"}, 64'(lpf_shift), 64'(m_lpf));
        check({tag, ".lock_en"},   64'(lock_en),   64'(m_lock));
        check({tag, ".demod_rst"}, 64'(demod_rst_n), 64'(m_drst));
        check({tag, ".addr_err"},  64'(addr_err),  64'(m_err));
        check({tag, ".gpio_ack"},  64'(gpio_ack),  64'(m_ack));
        check({tag, ".freq_upd"},  64'(freq_update), 64'd0);
    endtask

    // Issue one write at a negedge; measure ack latency in edges after the sampling edge
    task automatic do_write(input logic [15:0] a, input logic [31:0] d);
        logic ack0;
        ack0        = gpio_ack;
        gpio_addr   = a;
        gpio_data   = d;
        gpio_strobe = ~gpio_strobe;
        lat         = -1;
        pulses      = 0;
        pulse_at    = -1;
        pulse_word  = '0;
        for (int n = 0; n < 20 && lat < 0; n++) begin
            @(posedge clk);
            #1;
            if (freq_update) begin
                pulses++;
                pulse_at   = n;
                pulse_word = freq_word;
            end
            if (gpio_ack != ack0) lat = n;
        end
        model_write(a, d);
        @(negedge clk);
    endtask

    task automatic write_and_check(input string tag, input logic [15:0] a, input logic [31:0] d);
        do_write(a, d);
        check({tag, ".ack_lat"}, 64'(lat), 64'(ACK_LAT));
        check({tag, ".pulses"}, 64'(pulses), (a == A_FHI) ? 64'd1 : 64'd0);
        if (a == A_FHI) begin
            check({tag, ".pulse_at"}, 64'(pulse_at), 64'(ACK_LAT - 1));
            check({tag, ".pulse_word"}, 64'(pulse_word), 64'(m_freq));
        end
        check_regs(tag);
    endtask

    initial begin
        int          acks;
        logic        ack0;
        logic [15:0] ra;
        logic [31:0] rd;
        int          sel;

        n_total     = 0;
        n_bad       = 0;
        rst         = 1'b0;
        gpio_strobe = 1'b0;
        gpio_addr   = '0;
        gpio_data   = '0;
        model_reset();

        // Reset values
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_regs("reset");

        // Reset asserted while an lpf write sits in COMMIT
        gpio_addr   = A_LPF;
        gpio_data   = 32'd7;
        gpio_strobe = ~gpio_strobe;
        repeat (ACK_LAT - 1) @(posedge clk);
        @(negedge clk);
        rst         = 1'b0;
        gpio_strobe = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (ACK_LAT + 3) @(negedge clk);
        check("abort.lpf_shift", 64'(lpf_shift), 64'd10);
        check("abort.gpio_ack", 64'(gpio_ack), 64'd0);
        check_regs("abort");

        // Split 48-bit frequency write
        write_and_check("freq_lo", A_FLO, 32'hDEADBEEF);
        check("freq_lo.word0", 64'(freq_word), 64'd0);
        write_and_check("freq_hi", A_FHI, 32'h00001234);
        check("freq_hi.word", 64'(freq_word), 64'h0000_1234_DEAD_BEEF);

        write_and_check("phase", A_PHASE, 32'hFFFABCDE);
        check("phase.value", 64'(phase_off), 64'hABCDE);

        write_and_check("unmapped", 16'h0099, 32'h12345678);
        check("unmapped.err", 64'(addr_err), 64'd1);
        write_and_check("ctrl", A_CTRL, 32'h80000003);
        check("ctrl.err", 64'(addr_err), 64'd0);
        check("ctrl.lock", 64'(lock_en), 64'd1);
        check("ctrl.drst", 64'(demod_rst_n), 64'd1);

        // Second toggle arrives while the first write is in DECODE
        ack0        = gpio_ack;
        gpio_addr   = A_PHASE;
        gpio_data   = 32'h00054321;
        gpio_strobe = ~gpio_strobe;
        repeat (ACK_LAT - 2) @(posedge clk);
        @(negedge clk);
        gpio_addr   = A_LPF;
        gpio_data   = 32'h0000001B;
        gpio_strobe = ~gpio_strobe;
        acks = 0;
        for (int n = 0; n < 30 && acks < 2; n++) begin
            @(posedge clk);
            #1;
            if (gpio_ack != ack0) begin
                acks++;
                ack0 = gpio_ack;
            end
        end
        model_write(A_PHASE, 32'h00054321);
        model_write(A_LPF, 32'h0000001B);
        repeat (ACK_LAT + 4) @(negedge clk);
        check("b2b.acks", 64'(acks), 64'd2);
        check_regs("b2b");

        // Random register traffic
        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(0, 5));
            case (sel)
                0: ra = A_FLO;
                1: ra = A_FHI;
                2: ra = A_PHASE;
                3: ra = A_LPF;
                4: ra = A_CTRL;
                default: ra = 16'(16'h0020 + $urandom_range(0, 16'hFFD0));
            endcase
            rd = $urandom;
            write_and_check("rand", ra, rd);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
